// File: rtl/flux_sched_pkg.sv
// flux_sched_pkg: shared types and helpers for the FLUX round-robin scheduler.
//   sched_state_t : scheduler FSM states (RUN issues, DRAIN empties the pipe, DONE idles).
//   tag_t         : container for a flux tag inside the tag pipeline; wide enough for
//                   any practical FLUX, and narrowed to TAG_WIDTH at the ports.
//   next_ptr()    : round-robin pointer advance with wrap at flux-1.
package flux_sched_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_t;

  localparam int unsigned TagMaxWidth = 8;
  typedef logic [TagMaxWidth-1:0] tag_t;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned flux);
    return (ptr == flux - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/flux_rr_arbiter.sv
// flux_rr_arbiter: purely combinational round-robin arbiter over FLUX requesters.
// Optional macro FLUX_SCHED_STRICT_PRIO_EN adds i_prio_mask; masked eligible fluxes win,
// lowest index first, and o_prio flags such a grant so the caller can hold its pointer.
// Ports:
//   i_elig      in  FLUX       eligible requesters
//   i_rr_ptr    in  TAG_WIDTH  first index to consider
//   i_prio_mask in  FLUX       strict-priority mask (macro only)
//   o_grant     out FLUX       one-hot grant, zero when nobody is eligible
//   o_tag       out TAG_WIDTH  encoded grant index, zero when no grant
//   o_prio      out 1          grant came from the priority path
module flux_rr_arbiter
  import flux_sched_pkg::*;
#(
  parameter int unsigned FLUX      = 2,
  parameter int unsigned TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      i_elig,
  input  logic [TAG_WIDTH-1:0] i_rr_ptr,
`ifdef FLUX_SCHED_STRICT_PRIO_EN
  input  logic [FLUX-1:0]      i_prio_mask,
`endif
  output logic [FLUX-1:0]      o_grant,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_prio
);

  logic [TAG_WIDTH-1:0] w_idx;
  logic                 w_found;

  always_comb begin
    o_grant = '0;
    o_tag   = '0;
    o_prio  = 1'b0;
    w_found = 1'b0;
    w_idx   = '0;
`ifdef FLUX_SCHED_STRICT_PRIO_EN
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (!w_found && i_elig[i] && i_prio_mask[i]) begin
        w_found    = 1'b1;
        o_prio     = 1'b1;
        o_grant[i] = 1'b1;
        o_tag      = TAG_WIDTH'(i);
      end
    end
`endif
    // Scan rr_ptr, rr_ptr+1, ... modulo FLUX; first eligible wins.
    for (int unsigned k = 0; k < FLUX; k++) begin
      w_idx = TAG_WIDTH'((32'(i_rr_ptr) + k) % FLUX);
      if (!w_found && i_elig[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_tag          = w_idx;
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler: shares one PIPE_LAT-deep actor datapath across FLUX tagged streams
// using a registered round-robin pointer and per-flux output credits, and owns the tag
// pipeline that steers results into the output FIFOs.
// Optional macro FLUX_SCHED_STRICT_PRIO_EN adds input prio_mask (strict priority overlay).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_empty    in  FLUX       input FIFO empty flags (show-ahead FIFOs)
//   out_pop     in  FLUX       consumer pops of output FIFOs; each returns a credit
//   prio_mask   in  FLUX       priority mask (macro only)
//   flush_req   in  1          stop issuing and drain the pipeline
//   in_read     out FLUX       one-hot input FIFO read strobe
//   dp_valid    out 1          datapath stage-0 capture enable
//   dp_tag      out TAG_WIDTH  tag of the flux read this cycle
//   out_write   out FLUX       one-hot output FIFO write, PIPE_LAT cycles after the read
//   out_tag     out TAG_WIDTH  tag of the result leaving the datapath
//   flush_done  out 1          drained and idle
//   busy        out 1          any token in flight
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned OUT_DEPTH  = 16,
  localparam int unsigned TAG_WIDTH  = $clog2(FLUX),
  localparam int unsigned CRED_WIDTH = $clog2(OUT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      in_empty,
  input  logic [FLUX-1:0]      out_pop,
`ifdef FLUX_SCHED_STRICT_PRIO_EN
  input  logic [FLUX-1:0]      prio_mask,
`endif
  input  logic                 flush_req,
  output logic [FLUX-1:0]      in_read,
  output logic                 dp_valid,
  output logic [TAG_WIDTH-1:0] dp_tag,
  output logic [FLUX-1:0]      out_write,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 flush_done,
  output logic                 busy
);

  sched_state_t         r_state, w_state_next;
  logic [CRED_WIDTH-1:0] r_credit [FLUX];
  logic [TAG_WIDTH-1:0] r_rr_ptr;
  logic [PIPE_LAT-1:0]  r_pipe_vld;
  tag_t                 r_pipe_tag [PIPE_LAT];

  logic [FLUX-1:0]      w_elig;
  logic [FLUX-1:0]      w_grant;
  logic [TAG_WIDTH-1:0] w_grant_tag;
  logic                 w_prio_win;
  logic                 w_issue_ok;

  // rst gates issue so every output is 0 while reset is held, not only after an edge.
  assign w_issue_ok = (r_state == RUN) && !flush_req && !rst;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      w_elig[i] = !in_empty[i] && (r_credit[i] != '0) && w_issue_ok;
    end
  end

  flux_rr_arbiter #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_arbiter (
    .i_elig      (w_elig),
    .i_rr_ptr    (r_rr_ptr),
`ifdef FLUX_SCHED_STRICT_PRIO_EN
    .i_prio_mask (prio_mask),
`endif
    .o_grant     (w_grant),
    .o_tag       (w_grant_tag),
    .o_prio      (w_prio_win)
  );

  assign in_read  = w_grant;
  assign dp_valid = |w_grant;
  assign dp_tag   = w_grant_tag;
  assign busy     = |r_pipe_vld;

  // Priority grants leave the round-robin order untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (dp_valid && !w_prio_win) begin
      r_rr_ptr <= TAG_WIDTH'(next_ptr(32'(w_grant_tag), FLUX));
    end
  end

  // Credit = free slots in the output FIFO, counting tokens still in the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FLUX; i++) r_credit[i] <= CRED_WIDTH'(OUT_DEPTH);
    end else begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        if (w_grant[i] && !out_pop[i]) begin
          r_credit[i] <= r_credit[i] - CRED_WIDTH'(1);
        end else if (!w_grant[i] && out_pop[i] && (r_credit[i] != CRED_WIDTH'(OUT_DEPTH))) begin
          r_credit[i] <= r_credit[i] + CRED_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int unsigned s = 0; s < PIPE_LAT; s++) r_pipe_tag[s] <= '0;
    end else begin
      r_pipe_vld[0] <= dp_valid;
      r_pipe_tag[0] <= tag_t'(dp_tag);
      for (int unsigned s = 1; s < PIPE_LAT; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_tag[s] <= r_pipe_tag[s-1];
      end
    end
  end

  // Invalid stages always carry tag 0, so out_tag is 0 whenever nothing is written.
  always_comb begin
    out_write = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (r_pipe_vld[PIPE_LAT-1] && (r_pipe_tag[PIPE_LAT-1] == tag_t'(i))) out_write[i] = 1'b1;
    end
  end
  assign out_tag = r_pipe_tag[PIPE_LAT-1][TAG_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (flush_req) w_state_next = DRAIN;
      DRAIN:   if (!busy)     w_state_next = DONE;
      DONE:    if (!flush_req) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    flush_done = (r_state == DONE);
  end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
module tb_flux_rr_scheduler;
  localparam int FLUX      = 2;
  localparam int PIPE_LAT  = 3;
  localparam int OUT_DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_empty, out_pop, in_read, out_write;
  logic       flush_req, dp_valid, flush_done, busy;
  logic [0:0] dp_tag, out_tag;

  always #5 clk = ~clk;

  flux_rr_scheduler #(
    .FLUX      (FLUX),
    .PIPE_LAT  (PIPE_LAT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_empty   (in_empty),
    .out_pop    (out_pop),
    .flush_req  (flush_req),
    .in_read    (in_read),
    .dp_valid   (dp_valid),
    .dp_tag     (dp_tag),
    .out_write  (out_write),
    .out_tag    (out_tag),
    .flush_done (flush_done),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: integer credits, pointer, flush phase and a list of in-flight
  // tokens stamped with the cycle their result must appear.
  typedef struct { int tag; int due; } tok_t;
  tok_t tok_q[$];
  int   m_credit [FLUX];
  int   m_rr;
  int   m_phase;  // 0 issuing, 1 draining, 2 drained
  int   cyc = 0;
  bit   chk_en = 0;

  int   e_g, e_idx, e_wr, e_ot, e_c;
  bit   e_busy;

  task automatic model_reset();
    for (int i = 0; i < FLUX; i++) m_credit[i] = OUT_DEPTH;
    m_rr    = 0;
    m_phase = 0;
    tok_q.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      e_g = -1;
      if (m_phase == 0 && !flush_req) begin
        for (int k = 0; k < FLUX; k++) begin
          e_idx = (m_rr + k) % FLUX;
          if (e_g < 0 && !in_empty[e_idx] && m_credit[e_idx] > 0) e_g = e_idx;
        end
      end
      e_busy = (tok_q.size() > 0);
      e_wr   = 0;
      e_ot   = 0;
      if (tok_q.size() > 0 && tok_q[0].due == cyc) begin
        e_wr = 1 << tok_q[0].tag;
        e_ot = tok_q[0].tag;
      end
      check("in_read",    int'(in_read),    (e_g >= 0) ? (1 << e_g) : 0);
      check("dp_valid",   int'(dp_valid),   (e_g >= 0) ? 1 : 0);
      check("dp_tag",     int'(dp_tag),     (e_g >= 0) ? e_g : 0);
      check("out_write",  int'(out_write),  e_wr);
      check("out_tag",    int'(out_tag),    e_ot);
      check("busy",       int'(busy),       int'(e_busy));
      check("flush_done", int'(flush_done), (m_phase == 2) ? 1 : 0);
      // advance model by one clock
      if (e_wr != 0) void'(tok_q.pop_front());
      if (e_g >= 0) begin
        tok_q.push_back('{tag: e_g, due: cyc + PIPE_LAT});
        m_rr = (e_g + 1) % FLUX;
      end
      for (int i = 0; i < FLUX; i++) begin
        e_c = m_credit[i] - ((e_g == i) ? 1 : 0) + int'(out_pop[i]);
        m_credit[i] = (e_c > OUT_DEPTH) ? OUT_DEPTH : e_c;
      end
      case (m_phase)
        0: if (flush_req) m_phase = 1;
        1: if (!e_busy) m_phase = 2;
        default: if (!flush_req) m_phase = 0;
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  n0, n1, nw, nr;
  bit  seen, done;

  initial begin
    rst = 1'b1; in_empty = 2'b00; out_pop = 2'b00; flush_req = 1'b0;
    model_reset();
    #12;
    check("rst in_read",    int'(in_read),    0);
    check("rst dp_valid",   int'(dp_valid),   0);
    check("rst dp_tag",     int'(dp_tag),     0);
    check("rst out_write",  int'(out_write),  0);
    check("rst out_tag",    int'(out_tag),    0);
    check("rst busy",       int'(busy),       0);
    check("rst flush_done", int'(flush_done), 0);
    step();
    rst = 1'b0; chk_en = 1'b1;

    // Alternating grants until both credits are used up; writes trail by 3 cycles.
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      check("alt dp_valid", int'(dp_valid), (i < 32) ? 1 : 0);
      if (i < 32) check("alt dp_tag", int'(dp_tag), i % 2);
      check("alt out_write", int'(out_write), (i >= 3 && i < 35) ? (1 << ((i - 3) % 2)) : 0);
    end

    // Flux 1 gets 5 credits back, flux 0 none: only flux 1 may be served.
    step(); in_empty = 2'b11;
    for (int i = 0; i < 5; i++) begin step(); out_pop = 2'b10; end
    step(); out_pop = 2'b00; in_empty = 2'b00;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dp_valid && dp_tag == 1'b1) n1++;
      if (dp_valid && dp_tag == 1'b0) n0++;
      step();
    end
    check("credit5 flux1 grants", n1, 5);
    check("credit0 flux0 grants", n0, 0);
    out_pop = 2'b01;
    @(negedge clk); seen = in_read[0];
    step(); out_pop = 2'b00;
    @(negedge clk); seen |= in_read[0];
    check("pop0 regrant", int'(seen), 1);

    // Grant and pop of flux 1 in the same cycle at credit 1.
    step(); in_empty = 2'b11; out_pop = 2'b10;
    step(); in_empty = 2'b01; out_pop = 2'b10;
    @(negedge clk); check("grant+pop read", int'(in_read), 2);
    step(); out_pop = 2'b00;
    @(negedge clk); check("credit kept read", int'(in_read), 2);
    step();
    @(negedge clk); check("credit spent read", int'(in_read), 0);

    // Flush with 3 tokens in flight.
    step(); in_empty = 2'b11; out_pop = 2'b11;
    for (int i = 0; i < 9; i++) step();
    step(); out_pop = 2'b00; in_empty = 2'b00;
    step();
    step();
    step(); flush_req = 1'b1;
    nr = 0; nw = 0; done = 0;
    for (int i = 0; i < 15 && !done; i++) begin
      @(negedge clk);
      if (in_read != 2'b00) nr++;
      if (out_write != 2'b00) nw++;
      if (flush_done) done = 1;
      else step();
    end
    check("flush reads", nr, 0);
    check("flush writes", nw, 3);
    check("flush_done reached", int'(done), 1);
    step(); flush_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (dp_valid) begin
        seen = 1;
        check("resume tag", int'(dp_tag), 1);
      end else step();
    end
    check("resume grant", int'(seen), 1);

    // Async reset with tokens in flight.
    step(); step();
    @(posedge clk); #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst in_read",   int'(in_read),   0);
    check("arst dp_valid",  int'(dp_valid),  0);
    check("arst out_write", int'(out_write), 0);
    check("arst busy",      int'(busy),      0);
    step(); rst = 1'b0;
    n0 = 0; nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dp_valid) n0++;
      if (out_write != 2'b00) nw++;
      step();
    end
    check("post-reset grants", n0, 32);
    check("post-reset writes", nw, 32);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_empty = 2'($urandom);
      out_pop  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
      step();
    end
    flush_req = 1'b0; out_pop = 2'b00;
    for (int i = 0; i < 10; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
